// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct constants, datapath select encodings and instruction classes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] EXT_ZERO    = 2'b00;
  localparam logic [1:0] EXT_UPPER   = 2'b01;
  localparam logic [1:0] EXT_SIGN    = 2'b10;
  localparam logic [1:0] EXT_SIGN_SH = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [3:0] {
    I_ILL  = 4'd0,
    I_ADDU = 4'd1,
    I_SUBU = 4'd2,
    I_JR   = 4'd3,
    I_ORI  = 4'd4,
    I_LUI  = 4'd5,
    I_LW   = 4'd6,
    I_SW   = 4'd7,
    I_BEQ  = 4'd8,
    I_J    = 4'd9,
    I_JAL  = 4'd10
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct -> instruction class.
// Anything outside the supported subset (including nop/sll) maps to I_ILL.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] cls
);

  always_comb begin
    cls = I_ILL;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADDU: cls = I_ADDU;
          FN_SUBU: cls = I_SUBU;
          FN_JR:   cls = I_JR;
          default: cls = I_ILL;
        endcase
      end
      OP_ORI:  cls = I_ORI;
      OP_LUI:  cls = I_LUI;
      OP_LW:   cls = I_LW;
      OP_SW:   cls = I_SW;
      OP_BEQ:  cls = I_BEQ;
      OP_J:    cls = I_J;
      OP_JAL:  cls = I_JAL;
      default: cls = I_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational outputs.
// Optional retired-instruction counter enabled by defining MC_CTRL_RETIRE_CNT_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic       ALUSrc,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [2:0] state
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("mc_ctrl: CNT_W must be at least 1");
  end

  state_t     state_reg, state_next;
  logic [3:0] cls_bits;
  iclass_t    cls;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls_bits)
  );

  assign cls   = iclass_t'(cls_bits);
  assign state = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    RegWr  = 1'b0;
    MemWr  = 1'b0;
    ALUSrc = 1'b0;
    ExtOp  = EXT_ZERO;
    ALUOp  = ALU_ADD;
    RegDst = RD_RT;
    WDSel  = WD_ALU;
    NPCOp  = NPC_PC4;

    case (state_reg)
      S_FETCH: begin
        IRWr       = 1'b1;
        PCWr       = 1'b1;
        NPCOp      = NPC_PC4;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          I_J: begin
            PCWr  = 1'b1;
            NPCOp = NPC_J;
          end
          I_JAL: begin
            PCWr   = 1'b1;
            NPCOp  = NPC_J;
            RegWr  = 1'b1;
            RegDst = RD_RA;
            WDSel  = WD_PC;
          end
          I_JR: begin
            PCWr  = 1'b1;
            NPCOp = NPC_JR;
          end
          I_ILL:   state_next = S_FETCH;
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          I_ADDU: begin
            ALUOp      = ALU_ADD;
            state_next = S_WB;
          end
          I_SUBU: begin
            ALUOp      = ALU_SUB;
            state_next = S_WB;
          end
          I_ORI: begin
            ALUOp      = ALU_OR;
            ExtOp      = EXT_ZERO;
            ALUSrc     = 1'b1;
            state_next = S_WB;
          end
          I_LUI: begin
            ALUOp      = ALU_OR;
            ExtOp      = EXT_UPPER;
            ALUSrc     = 1'b1;
            state_next = S_WB;
          end
          I_LW, I_SW: begin
            ALUOp      = ALU_ADD;
            ExtOp      = EXT_SIGN;
            ALUSrc     = 1'b1;
            state_next = S_MEM;
          end
          // Branch resolves here: the comparison result gates the PC write.
          I_BEQ: begin
            ALUOp = ALU_SUB;
            ExtOp = EXT_SIGN_SH;
            NPCOp = NPC_BR;
            PCWr  = zero;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        case (cls)
          I_LW:    state_next = S_WB;
          I_SW:    MemWr = 1'b1;
          default: state_next = S_FETCH;
        endcase
      end
      S_WB: begin
        case (cls)
          I_ADDU, I_SUBU: begin
            RegWr  = 1'b1;
            RegDst = RD_RD;
            WDSel  = WD_ALU;
          end
          I_ORI, I_LUI: begin
            RegWr  = 1'b1;
            RegDst = RD_RT;
            WDSel  = WD_ALU;
          end
          I_LW: begin
            RegWr  = 1'b1;
            RegDst = RD_RT;
            WDSel  = WD_MEM;
          end
          default: RegWr = 1'b0;
        endcase
      end
      default: state_next = S_FETCH;
    endcase

    // Reset forces FETCH, but FETCH's own write enables must stay quiet while held.
    if (reset) begin
      PCWr   = 1'b0;
      IRWr   = 1'b0;
      RegWr  = 1'b0;
      MemWr  = 1'b0;
      ALUSrc = 1'b0;
      ExtOp  = EXT_ZERO;
      ALUOp  = ALU_ADD;
      RegDst = RD_RT;
      WDSel  = WD_ALU;
      NPCOp  = NPC_PC4;
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_reg;
  logic             retire;

  assign retire = (state_next == S_FETCH) &&
                  (state_reg inside {S_DECODE, S_EXEC, S_MEM, S_WB});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_reg <= '0;
    else if (retire) retired_reg <= retired_reg + CNT_W'(1);
  end

  assign retired = retired_reg;
`endif

endmodule
